// File: rtl/conv_cmd_sequencer_pkg.sv
// Shared opcodes, state codes and GPIO field positions for the
// convolution command sequencer and its firmware.
package conv_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LD_KER  = 3'd1,
    OP_LD_IMG  = 3'd2,
    OP_RUN     = 3'd3,
    OP_READ    = 3'd4,
    OP_CLR_ERR = 3'd5,
    OP_BAD6    = 3'd6,
    OP_BAD7    = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RUN     = 3'd2,
    ST_READ    = 3'd3,
    ST_ERRWAIT = 3'd4
  } state_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int TOG_BIT = 28;
  localparam int ACK_BIT = 31;
  localparam int ST_MSB  = 30;
  localparam int ST_LSB  = 28;
  localparam int ERR_BIT = 27;

endpackage

// File: rtl/conv_cmd_sequencer_cmd_field_decode.sv
// Toggle-edge command detect and GPIO field extraction.
// Ports: clk, rst, cmd (GPIO word) -> valid, op, addr, data.
module conv_cmd_sequencer_cmd_field_decode
  import conv_cmd_sequencer_pkg::*;
#(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cmd,
  output logic                  valid,
  output opcode_e               op,
  output logic [NB_ADDRESS-1:0] addr,
  output logic [NB_IMAGE-1:0]   data
);

  logic tog_q;
  logic unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tog_q <= 1'b0;
    else     tog_q <= cmd[TOG_BIT];
  end

  // A new command is any change of the toggle bit.
  assign valid = cmd[TOG_BIT] ^ tog_q;
  assign op    = opcode_e'(cmd[OP_MSB:OP_LSB]);
  assign addr  = cmd[NB_ADDRESS+NB_IMAGE-1:NB_IMAGE];
  assign data  = cmd[NB_IMAGE-1:0];

  assign unused_bits = ^cmd;

endmodule

// File: rtl/conv_cmd_sequencer.sv
// Sequences the convolution datapath from the GPIO command/status pair.
// Ports: GPIO cmd/stat, memory write, conv start/done, result read, LEDs.
module conv_cmd_sequencer
  import conv_cmd_sequencer_pkg::*;
#(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int NB_RESULT  = 13,
  parameter int RD_LATENCY = 2,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                  i_CLK,
  input  logic                  i_rst,
  input  logic [31:0]           i_gpio_cmd,
  output logic [31:0]           o_gpio_stat,
  output logic                  o_img_we,
  output logic                  o_ker_we,
  output logic [NB_ADDRESS-1:0] o_wr_addr,
  output logic [NB_IMAGE-1:0]   o_wr_data,
  output logic                  o_conv_start,
  output logic [NB_ADDRESS-1:0] o_conv_cols,
  input  logic                  i_conv_done,
  output logic                  o_res_re,
  output logic [NB_ADDRESS-1:0] o_res_addr,
  input  logic [NB_RESULT-1:0]  i_res_data,
  output logic [2:0]            o_led
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic                  cmd_valid;
  opcode_e               cmd_op;
  logic [NB_ADDRESS-1:0] cmd_addr;
  logic [NB_IMAGE-1:0]   cmd_data;

  state_e state, state_d;

  logic                  ack;
  logic                  err;
  logic [NB_RESULT-1:0]  rdata;
  logic [CNT_W-1:0]      cnt;
  logic [RD_LATENCY-1:0] rd_pipe;

  logic do_ker, do_img, do_run, do_read;
  logic do_ack, do_cap, set_err, clr_err;

  conv_cmd_sequencer_cmd_field_decode #(
    .NB_ADDRESS (NB_ADDRESS),
    .NB_IMAGE   (NB_IMAGE)
  ) u_decode (
    .clk   (i_CLK),
    .rst   (i_rst),
    .cmd   (i_gpio_cmd),
    .valid (cmd_valid),
    .op    (cmd_op),
    .addr  (cmd_addr),
    .data  (cmd_data)
  );

  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    do_ker  = 1'b0;
    do_img  = 1'b0;
    do_run  = 1'b0;
    do_read = 1'b0;
    do_ack  = 1'b0;
    do_cap  = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_NOP: do_ack = 1'b1;
            OP_LD_KER: begin
              do_ker  = 1'b1;
              do_ack  = 1'b1;
              state_d = ST_WRITE;
            end
            OP_LD_IMG: begin
              do_img  = 1'b1;
              do_ack  = 1'b1;
              state_d = ST_WRITE;
            end
            OP_RUN: begin
              do_run  = 1'b1;
              state_d = ST_RUN;
            end
            OP_READ: begin
              do_read = 1'b1;
              state_d = ST_READ;
            end
            OP_CLR_ERR: begin
              clr_err = 1'b1;
              do_ack  = 1'b1;
            end
            default: begin
              set_err = 1'b1;
              do_ack  = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_RUN: begin
        // Done has priority over an expiring timeout.
        if (i_conv_done) begin
          do_ack  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          do_ack  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_pipe[RD_LATENCY-1]) begin
          do_cap  = 1'b1;
          do_ack  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Commands arriving while busy are dropped and flagged.
    if (cmd_valid && state != ST_IDLE) set_err = 1'b1;
  end

  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) begin
      ack          <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      cnt          <= '0;
      rd_pipe      <= '0;
      o_img_we     <= 1'b0;
      o_ker_we     <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_conv_start <= 1'b0;
      o_conv_cols  <= '0;
      o_res_re     <= 1'b0;
      o_res_addr   <= '0;
    end else begin
      if (do_ack) ack <= ~ack;
      if (clr_err)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (do_cap) rdata <= i_res_data;
      if (do_run)              cnt <= '0;
      else if (state == ST_RUN) cnt <= cnt + CNT_W'(1);
      // Tap RD_LATENCY-1 lines up with the capture edge.
      rd_pipe  <= (rd_pipe << 1) | RD_LATENCY'(do_read);
      o_img_we <= do_img;
      o_ker_we <= do_ker;
      if (do_img || do_ker) begin
        o_wr_addr <= cmd_addr;
        o_wr_data <= cmd_data;
      end
      o_conv_start <= do_run;
      if (do_run) o_conv_cols <= cmd_addr;
      o_res_re <= do_read;
      if (do_read) o_res_addr <= cmd_addr;
    end
  end

  always_comb begin
    o_gpio_stat                  = '0;
    o_gpio_stat[ACK_BIT]         = ack;
    o_gpio_stat[ST_MSB:ST_LSB]   = state;
    o_gpio_stat[ERR_BIT]         = err;
    o_gpio_stat[NB_RESULT-1:0]   = rdata;
  end

  assign o_led = state;

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// Directed plus randomized bench for conv_cmd_sequencer against a
// transaction-level model of the command protocol.
module tb_conv_cmd_sequencer;

  localparam int NA = 10;
  localparam int NI = 10;
  localparam int NR = 13;
  localparam int L  = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cmd;
  logic [31:0]   stat;
  logic          img_we, ker_we, conv_start, res_re, done;
  logic [NA-1:0] wr_addr, conv_cols, res_addr;
  logic [NI-1:0] wr_data;
  logic [NR-1:0] res_data;
  logic [2:0]    led;

  int checks = 0;
  int errors = 0;

  logic          m_tog, m_ack, m_err;
  logic [NR-1:0] m_rdata;
  logic [NA-1:0] m_wa, m_cols, m_ra;
  logic [NI-1:0] m_wd;
  logic [NR-1:0] mem [1024];

  always #5 clk = ~clk;

  conv_cmd_sequencer #(
    .NB_ADDRESS (NA),
    .NB_IMAGE   (NI),
    .NB_RESULT  (NR),
    .RD_LATENCY (L),
    .TIMEOUT    (TO)
  ) dut (
    .i_CLK        (clk),
    .i_rst        (rst),
    .i_gpio_cmd   (cmd),
    .o_gpio_stat  (stat),
    .o_img_we     (img_we),
    .o_ker_we     (ker_we),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_conv_start (conv_start),
    .o_conv_cols  (conv_cols),
    .i_conv_done  (done),
    .o_res_re     (res_re),
    .o_res_addr   (res_addr),
    .i_res_data   (res_data),
    .o_led        (led)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_of(input logic [2:0] st);
    logic [31:0] s;
    s = 32'd0;
    s[31] = m_ack;
    s[30:28] = st;
    s[27] = m_err;
    s[NR-1:0] = m_rdata;
    return s;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".stat"}, stat, stat_of(3'd0));
    chk({tag, ".led"}, led, 3'd0);
    chk({tag, ".strb"}, {img_we, ker_we, conv_start, res_re}, 4'd0);
    chk({tag, ".regs"}, {wr_addr, wr_data, conv_cols, res_addr},
        {m_wa, m_wd, m_cols, m_ra});
  endtask

  task automatic model_reset();
    m_tog = 0; m_ack = 0; m_err = 0; m_rdata = '0;
    m_wa = '0; m_wd = '0; m_cols = '0; m_ra = '0;
  endtask

  task automatic send(input logic [2:0] op, input logic [NA-1:0] a,
                      input logic [NI-1:0] d);
    m_tog = ~m_tog;
    cmd = {op, m_tog, 8'($urandom), a, d};
  endtask

  task automatic send_drop();
    send(3'($urandom), NA'($urandom), NI'($urandom));
    m_err = 1'b1;
  endtask

  task automatic do_simple(input logic [2:0] op);
    send(op, NA'($urandom), NI'($urandom));
    @(negedge clk);
    m_ack = ~m_ack;
    if (op == 3'd5) m_err = 1'b0;
    if (op >= 3'd6) m_err = 1'b1;
    chk_quiet("simple");
  endtask

  task automatic do_write(input logic [2:0] op, input logic [NA-1:0] a,
                          input logic [NI-1:0] d, input bit drop);
    send(op, a, d);
    @(negedge clk);
    m_ack = ~m_ack;
    m_wa = a;
    m_wd = d;
    chk("wr.stat", stat, stat_of(3'd1));
    chk("wr.we", {img_we, ker_we}, {op == 3'd2, op == 3'd1});
    chk("wr.regs", {wr_addr, wr_data}, {a, d});
    if (drop) send_drop();
    @(negedge clk);
    chk_quiet("wr.end");
  endtask

  task automatic do_run(input logic [NA-1:0] cols, input int d,
                        input int drop_at);
    int last;
    last = (d != 0) ? d : TO;
    send(3'd3, cols, NI'($urandom));
    @(negedge clk);
    m_cols = cols;
    chk("run.start", {conv_start, led, conv_cols}, {1'b1, 3'd2, cols});
    chk("run.ack0", stat[31], m_ack);
    for (int k = 1; k <= last; k++) begin
      done = (k == d);
      if (k == drop_at) send_drop();
      @(negedge clk);
      if (k < last) begin
        chk("run.busy", {conv_start, led, stat[31]}, {1'b0, 3'd2, m_ack});
      end
    end
    done = 1'b0;
    if (d == 0) m_err = 1'b1;
    m_ack = ~m_ack;
    chk_quiet("run.end");
  endtask

  task automatic do_read(input logic [NA-1:0] a, input bit drop);
    send(3'd4, a, NI'($urandom));
    @(negedge clk);
    m_ra = a;
    chk("rd.strobe", {res_re, led, res_addr}, {1'b1, 3'd3, a});
    for (int i = 1; i <= L; i++) begin
      res_data = (i == L) ? mem[a] : ~mem[a];
      if (drop && i == 1) send_drop();
      @(negedge clk);
      if (i < L) chk("rd.wait", {res_re, led, stat[31]}, {1'b0, 3'd3, m_ack});
    end
    res_data = NR'($urandom);
    m_ack = ~m_ack;
    m_rdata = mem[a];
    chk_quiet("rd.end");
  endtask

  initial begin
    logic [2:0] op;
    int d, last, drop_at;
    for (int i = 0; i < 1024; i++) mem[i] = NR'($urandom);
    mem[10'h3FF] = 13'h1ABC;
    model_reset();
    rst = 1'b1;
    cmd = 32'd0;
    done = 1'b0;
    res_data = '0;
    #2;
    chk_quiet("reset.async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset.idle");

    do_write(3'd2, 10'h155, 10'h2AA, 1'b0);
    chk("ld_img.ack", stat[31], 1'b1);
    do_write(3'd1, 10'h007, 10'h3FF, 1'b0);
    do_run(10'h080, 10, 0);
    chk("run.noerr", stat[27], 1'b0);
    do_run(10'h003, 0, 0);
    chk("timeout.err", stat[27], 1'b1);
    do_simple(3'd5);
    chk("clr.err", stat[27], 1'b0);
    do_read(10'h3FF, 1'b0);
    chk("read.data", stat[12:0], 13'h1ABC);
    do_run(10'h011, 8, 3);
    chk("drop.err", stat[27], 1'b1);
    do_simple(3'd5);
    do_simple(3'd7);
    do_simple(3'd5);
    do_run(10'h2F0, TO, 0);
    chk("done_at_to.noerr", stat[27], 1'b0);
    do_run(10'h001, 1, 0);
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk_quiet("done.idle");
    do_simple(3'd0);
    do_simple(3'd6);
    do_write(3'd1, 10'h00C, 10'h155, 1'b1);
    do_read(10'h123, 1'b1);
    do_simple(3'd5);

    send(3'd3, 10'h0AA, 10'h000);
    @(negedge clk);
    chk("rst.run.start", conv_start, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    cmd = 32'd0;
    #1;
    model_reset();
    chk_quiet("rst.mid_run");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet("rst.after");
    end

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom);
      case (op)
        3'd1, 3'd2:
          do_write(op, NA'($urandom), NI'($urandom),
                   $urandom_range(0, 3) == 0);
        3'd3: begin
          d = $urandom_range(0, TO);
          last = (d != 0) ? d : TO;
          drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last) : 0;
          do_run(NA'($urandom), d, drop_at);
        end
        3'd4: do_read(NA'($urandom), $urandom_range(0, 3) == 0);
        default: do_simple(op);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_quiet("rand.stray_done");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
